// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one result bit per clock,
// shift-add multiply and restoring divide on magnitudes with a final sign fix-up.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       count;
  logic [2*WIDTH:0]    acc, acc_step;
  logic [WIDTH:0]      rem, rem_step;
  logic [WIDTH-1:0]    opnd;
  logic                is_div, neg_q, neg_r, b_zero;
  logic                accept, last;

  logic                sgn, sa, sb;
  logic [WIDTH-1:0]    abs_a, abs_b;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  prod, prod_fin;
  logic [WIDTH-1:0]    quo, quo_fin, rem_fin;

  assign busy = (state == RUN);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count == CW'(1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sgn   = ~op[0];
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;

    // Multiply: acc = {spare, product-high, multiplier/product-low}; add then shift right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: acc low half shifts dividend bits out and quotient bits in.
    div_diff = {rem, acc[WIDTH-1]} - {2'b00, opnd};

    if (is_div) begin
      acc_step = {acc[2*WIDTH:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH+1]};
      rem_step = div_diff[WIDTH+1] ? {rem[WIDTH-1:0], acc[WIDTH-1]} : div_diff[WIDTH:0];
    end else begin
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
      rem_step = rem;
    end

    prod     = acc_step[2*WIDTH-1:0];
    prod_fin = neg_q ? -prod : prod;
    quo      = acc_step[WIDTH-1:0];
    quo_fin  = b_zero ? '1 : (neg_q ? -quo : quo);
    rem_fin  = neg_r ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      acc         <= '0;
      rem         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (accept) begin
        is_div <= op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        b_zero <= op[1] && (b == '0);
        opnd   <= op[1] ? abs_b : abs_a;
        acc    <= {{(WIDTH+1){1'b0}}, (op[1] ? abs_a : abs_b)};
        rem    <= '0;
        count  <= CW'(WIDTH);
      end else if (state == RUN && !flush) begin
        acc   <= acc_step;
        rem   <= rem_step;
        count <= count - CW'(1);
        if (last) begin
          done        <= 1'b1;
          div_by_zero <= b_zero;
          if (is_div) begin
            hi <= rem_fin;
            lo <= quo_fin;
          end else begin
            hi <= prod_fin[2*WIDTH-1:WIDTH];
            lo <= prod_fin[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule
